sha256_host: RTL and testbench
==============================

SHA256_HOST -- requirements
Module: sha256_host

Interface
- REQ-001 SHALL use one clock; reset is synchronous and active-high.
- REQ-002 Parameters SHALL be as listed, one per line: name, default, meaning.
  - WORDS, 20: message length in 32-bit words; matches the engine size of 80 bytes.
  - MSG_BASE, 16'h0000: memory address of the first message word.
  - OUT_BASE, 16'h0100: memory address of the first hash word.
  - DONE_TMO, 8: cycles allowed for eng_done to fall after eng_start.
- REQ-003 Ports SHALL be as listed, one per line: name, direction, width, meaning.
  - clk, in, 1: clock; memory is clocked on the same edge.
  - reset, in, 1: synchronous, active-high.
  - msg_valid, in, 1: message word offered.
  - msg_data, in, 32: message word, big-endian byte order.
  - msg_last, in, 1: final word of the message.
  - msg_ready, out, 1: word accepted when msg_valid and msg_ready are both high.
  - mem_we, out, 1: memory write enable.
  - mem_addr, out, 16: memory address.
  - mem_write_data, out, 32: memory write data.
  - mem_read_data, in, 32: read data, valid one cycle after its address.
  - eng_start, out, 1: start pulse to the hash engine.
  - eng_msg_addr, out, 16: constant MSG_BASE.
  - eng_out_addr, out, 16: constant OUT_BASE.
  - eng_done, in, 1: engine idle/done; high whenever the engine is idle.
  - hash_valid, out, 1: hash word offered.
  - hash_data, out, 32: hash word h0..h7, in order.
  - hash_last, out, 1: high with h7.
  - hash_ready, in, 1: downstream accepts the hash word.
  - busy, out, 1: high whenever state is not IDLE.
  - err, out, 1: sticky protocol error flag.

Function
- REQ-004 States SHALL be IDLE, LOAD, START, WAIT_LO, WAIT_HI, READ and SEND.
- REQ-005 msg_ready SHALL be 1 only in IDLE and LOAD.
- REQ-006 In IDLE, an accepted beat SHALL clear err, set the word count to 1 and move the state to LOAD.
- REQ-007 Each accepted beat SHALL drive mem_we=1, mem_addr=MSG_BASE+count and mem_write_data=msg_data, all registered, in the cycle after acceptance.
- REQ-008 In cycles with no accepted beat, mem_we SHALL be 0.
- REQ-009 Address arithmetic SHALL be 16-bit and wrap modulo 2^16.
- REQ-010 On acceptance of word number WORDS, the state SHALL move to START, with msg_ready low from the next cycle.
- REQ-011 If msg_last is high on a beat other than number WORDS, or low on beat number WORDS, err SHALL be set; the word count alone governs progress.
- REQ-012 START SHALL last one cycle with eng_start=1 and mem_we=0, then move to WAIT_LO.
- REQ-013 eng_start SHALL be 0 in every other state.
- REQ-014 WAIT_LO SHALL move to WAIT_HI on the first cycle with eng_done=0.
- REQ-015 If eng_done is still 1 after DONE_TMO cycles in WAIT_LO, err SHALL be set and the state SHALL return to IDLE with no hash output.
- REQ-016 WAIT_HI SHALL move to READ on the first cycle with eng_done=1; there SHALL be no timeout in WAIT_HI.
- REQ-017 READ SHALL drive mem_addr=OUT_BASE+k with mem_we=0 for k=0..7 on consecutive cycles.
- REQ-018 READ SHALL capture mem_read_data into hbuf[k] one cycle after each address, then move to SEND; READ lasts 9 cycles.
- REQ-019 In SEND, hash_valid SHALL be 1, hash_data SHALL be hbuf[idx] and hash_last SHALL equal (idx==7).
- REQ-020 idx SHALL increment on each hash_valid and hash_ready cycle.
- REQ-021 hash_data SHALL be held stable while hash_ready is low.
- REQ-022 Acceptance of idx 7 SHALL return the state to IDLE, with hash_valid low in the next cycle.
- REQ-023 eng_msg_addr and eng_out_addr SHALL be constants.
- REQ-024 msg_valid outside IDLE and LOAD SHALL be ignored and SHALL produce no write.

Reset
- REQ-025 Reset SHALL drive state to IDLE, count and idx to 0, and err to 0.
- REQ-026 Reset SHALL drive mem_we, eng_start, hash_valid, hash_last and busy to 0, and mem_addr, mem_write_data and hash_data to 0.
- REQ-027 Reset asserted mid-operation SHALL take effect at the next edge, discard any pending memory write and abandon the engine wait; hbuf contents are don't-care.
- REQ-028 The first msg_ready=1 after reset SHALL occur in the cycle after reset deasserts.

Verification
- REQ-029 Nominal run: 20 words 32'h00000000..32'h00000013 with msg_last on word 20; engine stub drops eng_done 2 cycles after eng_start and raises it 100 cycles later; memory preloaded with 32'hA0..32'hA7 at 16'h0100.. -> writes seen at 16'h0000..16'h0013; exactly one eng_start pulse; hash words A0..A7 emitted with hash_last on A7; err=0.
- REQ-030 Backpressure: hash_ready toggled 1,0,0,1 repeatedly -> each word is held stable until accepted; 8 beats total; no duplicates or skips.
- REQ-031 Early msg_last on word 5 -> err=1; all 20 words are still written; the flow completes normally.
- REQ-032 eng_done held high -> err=1 after DONE_TMO (8) cycles in WAIT_LO; return to IDLE; hash_valid never asserts.
- REQ-033 Reset asserted for 1 cycle during LOAD after word 7 -> no further mem_we; all outputs 0; a fresh 20-word message then completes correctly.
- REQ-034 Idle-gap input: msg_valid low for 3 cycles between words 10 and 11 -> addresses stay contiguous and mem_we=0 during the gap.

Source files
------------

// File: rtl/sha256_host.sv
// sha256_host: sequences one SHA-256 job through a shared memory and an
// external hash engine.
//   1. Streams WORDS message words into memory starting at MSG_BASE.
//   2. Pulses eng_start, waits for eng_done to fall (bounded by DONE_TMO)
//      and then rise again (unbounded).
//   3. Reads the eight hash words from OUT_BASE into a local buffer and
//      offers them downstream with a valid/ready handshake.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   msg_valid/data/last   message word stream in, msg_ready handshake out
//   mem_we/addr/write_data/read_data
//                         shared memory port, read data one cycle after address
//   eng_start, eng_done   engine start pulse / engine idle flag
//   eng_msg_addr/out_addr constant buffer addresses for the engine
//   hash_valid/data/last  hash word stream out, hash_ready handshake in
//   busy                  high whenever the controller is not idle
//   err                   sticky protocol / timeout error
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for the first message word
// LOAD    | accepting words 2..WORDS and writing them to memory
// START   | one-cycle eng_start pulse
// WAIT_LO | waiting for eng_done to fall, bounded by DONE_TMO cycles
// WAIT_HI | waiting for eng_done to rise again (engine finished)
// READ    | 8 reads from OUT_BASE plus one cycle for the last read data
// SEND    | offering hbuf[idx] downstream

module sha256_host #(
    parameter int          WORDS    = 20,
    parameter logic [15:0] MSG_BASE = 16'h0000,
    parameter logic [15:0] OUT_BASE = 16'h0100,
    parameter int          DONE_TMO = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msg_valid,
    input  logic [31:0] msg_data,
    input  logic        msg_last,
    output logic        msg_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        eng_start,
    output logic [15:0] eng_msg_addr,
    output logic [15:0] eng_out_addr,
    input  logic        eng_done,
    output logic        hash_valid,
    output logic [31:0] hash_data,
    output logic        hash_last,
    input  logic        hash_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] WORDS_W = 16'(WORDS);
    localparam logic [7:0]  TMO_LD  = 8'(DONE_TMO - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        START   = 3'd2,
        WAIT_LO = 3'd3,
        WAIT_HI = 3'd4,
        READ    = 3'd5,
        SEND    = 3'd6
    } state_t;

    state_t      state, state_nx;
    logic [15:0] count;
    logic [2:0]  idx;
    logic [3:0]  rd_cnt;
    logic [3:0]  rd_prev;
    logic [7:0]  tmo;
    logic [31:0] hbuf [8];

    logic        accept;
    logic [15:0] beat_num;
    logic        last_beat;

    // The first beat always restarts the count, whatever was left from the
    // previous message.
    assign beat_num  = (state == IDLE) ? 16'd1 : count + 16'd1;
    assign last_beat = (beat_num == WORDS_W);
    assign rd_prev   = rd_cnt - 4'd1;

    // Gated by reset so no word can be accepted in a cycle that is being
    // thrown away by the reset edge.
    assign msg_ready = ~reset & ((state == IDLE) | (state == LOAD));
    assign accept    = msg_valid & msg_ready;

    assign eng_start    = (state == START);
    assign eng_msg_addr = MSG_BASE;
    assign eng_out_addr = OUT_BASE;
    assign busy         = (state != IDLE);
    assign hash_valid   = (state == SEND);
    assign hash_data    = (state == SEND) ? hbuf[idx] : 32'd0;
    assign hash_last    = (state == SEND) && (idx == 3'd7);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = last_beat ? START : LOAD;
            LOAD:    if (accept && last_beat) state_nx = START;
            START:   state_nx = WAIT_LO;
            WAIT_LO: begin
                if (!eng_done)        state_nx = WAIT_HI;
                else if (tmo == 8'd0) state_nx = IDLE;
            end
            WAIT_HI: if (eng_done) state_nx = READ;
            READ:    if (rd_cnt == 4'd8) state_nx = SEND;
            SEND:    if (hash_ready && idx == 3'd7) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            count          <= 16'd0;
            idx            <= 3'd0;
            rd_cnt         <= 4'd0;
            tmo            <= 8'd0;
            err            <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 16'd0;
            mem_write_data <= 16'd0;
        end else begin
            state  <= state_nx;
            mem_we <= accept;

            if (accept) begin
                mem_addr       <= MSG_BASE + beat_num - 16'd1;
                mem_write_data <= msg_data;
                count          <= beat_num;
                // A fresh message clears the flag, but a misplaced msg_last on
                // that same first beat still sets it.
                err <= (msg_last != last_beat) | ((state == IDLE) ? 1'b0 : err);
            end

            if (state == START)
                tmo <= TMO_LD;

            if (state == WAIT_LO) begin
                if (eng_done && tmo == 8'd0) err <= 1'b1;
                else                         tmo <= tmo - 8'd1;
            end

            if (state == WAIT_HI && eng_done) begin
                mem_addr <= OUT_BASE;
                rd_cnt   <= 4'd0;
            end

            if (state == READ) begin
                rd_cnt <= rd_cnt + 4'd1;
                idx    <= 3'd0;
                if (rd_cnt < 4'd7)
                    mem_addr <= OUT_BASE + 16'(rd_cnt) + 16'd1;
            end

            if (state == SEND && hash_ready)
                idx <= idx + 3'd1;
        end
    end

    // Read data lags its address by one cycle, so READ cycle n captures the
    // word addressed in cycle n-1. No reset: contents are only visible in SEND.
    always_ff @(posedge clk) begin
        if (state == READ && rd_cnt != 4'd0)
            hbuf[rd_prev[2:0]] <= mem_read_data;
    end

endmodule

// File: tb/tb_sha256_host.sv
module tb_sha256_host;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        msg_valid = 1'b0;
    logic [31:0] msg_data = 32'd0;
    logic        msg_last = 1'b0;
    logic        msg_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = 32'd0;
    logic        eng_start;
    logic [15:0] eng_msg_addr;
    logic [15:0] eng_out_addr;
    logic        eng_done;
    logic        hash_valid;
    logic [31:0] hash_data;
    logic        hash_last;
    logic        hash_ready = 1'b1;
    logic        busy;
    logic        err;

    sha256_host dut (
        .clk(clk), .reset(reset),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
        .msg_ready(msg_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .eng_start(eng_start), .eng_msg_addr(eng_msg_addr), .eng_out_addr(eng_out_addr),
        .eng_done(eng_done),
        .hash_valid(hash_valid), .hash_data(hash_data), .hash_last(hash_last),
        .hash_ready(hash_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: hash words at 0x100..0x107 derive from hash_seed,
    // everything else returns a recognisable filler.
    logic [31:0] hash_seed = 32'hA0;
    always @(posedge clk) begin
        if (mem_addr >= 16'h0100 && mem_addr < 16'h0108)
            mem_read_data <= hash_seed + 32'(mem_addr - 16'h0100);
        else
            mem_read_data <= 32'hDEAD_0000 | 32'(mem_addr);
    end

    // Engine stub: eng_done drops 2 cycles after eng_start, rises 100 later.
    logic stuck = 1'b0;
    int   eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_start)                     eng_cnt <= 1;
        else if (eng_cnt != 0 && eng_cnt < 200) eng_cnt <= eng_cnt + 1;
    end
    assign eng_done = stuck | !(eng_cnt >= 2 && eng_cnt < 102);

    // Downstream: hash_ready follows 1,0,0,1 in backpressure mode.
    logic       bp_mode = 1'b0;
    logic [1:0] bp_ph = 2'd0;
    logic [3:0] bp_pat = 4'b1001;
    always @(posedge clk) begin
        #1;
        bp_ph = bp_ph + 2'd1;
        hash_ready = bp_mode ? bp_pat[bp_ph] : 1'b1;
    end

    // Monitors, sampled mid-cycle.
    logic [15:0] wq_addr [$];
    logic [31:0] wq_data [$];
    logic [31:0] hq [$];
    logic        lq [$];
    int          start_pulses = 0;
    int          hv_cycles = 0;
    logic        prev_hv = 1'b0, prev_hr = 1'b0;
    logic [31:0] prev_hd = 32'd0;

    always @(negedge clk) begin
        if (mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_write_data);
        end
        if (eng_start) start_pulses++;
        if (hash_valid) hv_cycles++;
        if (hash_valid && hash_ready) begin
            hq.push_back(hash_data);
            lq.push_back(hash_last);
        end
        if (prev_hv && !prev_hr) begin
            chk("hold_valid", 32'(hash_valid), 32'd1);
            chk("hold_data", hash_data, prev_hd);
        end
        prev_hv = hash_valid;
        prev_hr = hash_ready;
        prev_hd = hash_data;
    end

    typedef struct {
        int          last_at;
        int          gap_after;
        bit          bp;
        logic [31:0] dbase;
        logic [31:0] hseed;
        bit          exp_err;
    } scen_t;

    scen_t tbl [5];

    task automatic clear_mon();
        wq_addr.delete(); wq_data.delete(); hq.delete(); lq.delete();
        start_pulses = 0;
        hv_cycles = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_hash_valid"}, 32'(hash_valid), 32'd0);
        chk({tag, "_hash_last"}, 32'(hash_last), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_write_data, 32'd0);
        chk({tag, "_hash_data"}, hash_data, 32'd0);
    endtask

    // Drives n words; word i carries dbase+i-1. Idle gap of 3 cycles after
    // word gap_after. For a full message, checks the START cycle afterwards.
    task automatic send_msg(input int n, input int last_at, input int gap_after,
                            input logic [31:0] dbase);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            msg_valid = 1'b1;
            msg_data  = dbase + 32'(i - 1);
            msg_last  = (i == last_at);
            @(negedge clk);
            if (!msg_ready) chk("msg_ready_load", 32'(msg_ready), 32'd1);
            if (i == gap_after) begin
                @(posedge clk); #1;
                msg_valid = 1'b0;
                msg_last  = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    chk("gap_mem_we", 32'(mem_we), (k == 1) ? 32'd1 : 32'd0);
                    if (k < 3) begin @(posedge clk); #1; end
                end
            end
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        if (n == 20) begin
            @(negedge clk);
            chk("start_msg_ready", 32'(msg_ready), 32'd0);
            chk("start_eng_start", 32'(eng_start), 32'd1);
        end
    endtask

    task automatic wait_idle(input int max_cycles, output int used);
        used = -1;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            if (!busy) begin used = c; break; end
        end
        if (used < 0) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_scen(input scen_t s, input string tag);
        int used;
        clear_mon();
        hash_seed = s.hseed;
        bp_mode   = s.bp;
        send_msg(20, s.last_at, s.gap_after, s.dbase);
        wait_idle(400, used);
        bp_mode = 1'b0;
        @(negedge clk);
        chk({tag, "_writes"}, 32'(wq_addr.size()), 32'd20);
        for (int i = 0; i < 20 && i < wq_addr.size(); i++) begin
            chk({tag, "_waddr"}, 32'(wq_addr[i]), 32'(i));
            chk({tag, "_wdata"}, wq_data[i], s.dbase + 32'(i));
        end
        chk({tag, "_starts"}, 32'(start_pulses), 32'd1);
        chk({tag, "_beats"}, 32'(hq.size()), 32'd8);
        for (int k = 0; k < 8 && k < hq.size(); k++) begin
            chk({tag, "_hash"}, hq[k], s.hseed + 32'(k));
            chk({tag, "_hlast"}, 32'(lq[k]), (k == 7) ? 32'd1 : 32'd0);
        end
        chk({tag, "_err"}, 32'(err), 32'(s.exp_err));
        chk({tag, "_hv_after"}, 32'(hash_valid), 32'd0);
    endtask

    initial begin
        int used;
        int n;

        tbl[0] = '{last_at: 20, gap_after: 0,  bp: 1'b0, dbase: 32'h0,        hseed: 32'hA0,       exp_err: 1'b0};
        tbl[1] = '{last_at: 5,  gap_after: 0,  bp: 1'b0, dbase: 32'h1000_0000, hseed: 32'hB0,       exp_err: 1'b1};
        tbl[2] = '{last_at: 20, gap_after: 0,  bp: 1'b1, dbase: 32'h0000_0100, hseed: 32'hC0C0_0000, exp_err: 1'b0};
        tbl[3] = '{last_at: 0,  gap_after: 0,  bp: 1'b0, dbase: 32'h0000_0200, hseed: 32'h1234_5670, exp_err: 1'b1};
        tbl[4] = '{last_at: 20, gap_after: 10, bp: 1'b0, dbase: 32'hFFFF_FFF0, hseed: 32'hA0,       exp_err: 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        chk("rst_msg_ready", 32'(msg_ready), 32'd0);
        chk("eng_msg_addr", 32'(eng_msg_addr), 32'h0000);
        chk("eng_out_addr", 32'(eng_out_addr), 32'h0100);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("first_msg_ready", 32'(msg_ready), 32'd1);

        for (int t = 0; t < 5; t++)
            run_scen(tbl[t], $sformatf("scen%0d", t));

        // Engine never drops eng_done: timeout after DONE_TMO cycles in WAIT_LO.
        clear_mon();
        stuck = 1'b1;
        send_msg(20, 20, 0, 32'h0);
        n = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (!busy) begin n = c; break; end
        end
        chk("tmo_cycles", 32'(n), 32'd9);
        chk("tmo_err", 32'(err), 32'd1);
        repeat (5) @(negedge clk);
        chk("tmo_no_hash", 32'(hv_cycles), 32'd0);
        chk("tmo_starts", 32'(start_pulses), 32'd1);
        stuck = 1'b0;

        // Reset mid-load after word 7.
        clear_mon();
        send_msg(7, 0, 0, 32'h0000_5500);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_msg_ready", 32'(msg_ready), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        chk("midrst_ready_after", 32'(msg_ready), 32'd1);
        repeat (4) @(negedge clk);
        chk("midrst_writes", 32'(wq_addr.size()), 32'd7);
        chk("midrst_busy", 32'(busy), 32'd0);
        run_scen(tbl[0], "after_rst");

        wait_idle(10, used);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
